// File: rtl/cpu_pkg.sv
// Shared CPU datapath types and widths for the register file and scoreboard.
package cpu_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned CNT_W      = 2;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     word_t;
  typedef logic [CNT_W-1:0]      cnt_t;

  localparam reg_addr_t REG_ZERO = REG_ADDR_W'(0);
  localparam cnt_t      CNT_MAX  = CNT_W'(3);

endpackage : cpu_pkg

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write counters with issue/writeback/flush tracking.
// Optional feature: REGFILE_WB_BYPASS_EN treats a same-cycle final writeback as resolved.
import cpu_pkg::*;

module regfile_scoreboard (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_regwr,
  input  logic [REG_ADDR_W-1:0] wr_regdst_addr,
  input  logic                  issue_valid,
  input  logic                  issue_regwr,
  input  logic [REG_ADDR_W-1:0] issue_dst_addr,
  input  logic                  flush_i,
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [REG_ADDR_W-1:0] rt_addr,
  output logic                  rs_resolved_o,
  output logic                  rt_resolved_o
);

  cnt_t                cnt_q [NUM_REGS];
  cnt_t                cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0] inc_c;
  logic [NUM_REGS-1:0] dec_c;
  logic                inc_hit_c;
  logic                wb_hit_c;

  // Decode issue and writeback into per-register inc/dec strobes.
  always_comb begin
    inc_c     = '0;
    dec_c     = '0;
    inc_hit_c = issue_valid && issue_regwr && (issue_dst_addr != REG_ZERO);
    wb_hit_c  = wr_regwr && (wr_regdst_addr != REG_ZERO);
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      inc_c[i] = inc_hit_c && (issue_dst_addr == REG_ADDR_W'(i));
      dec_c[i] = wb_hit_c && (wr_regdst_addr == REG_ADDR_W'(i)) && (cnt_q[i] != '0);
    end
  end

  // Saturating counter update; flush wipes every pending entry.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (inc_c[i] && !dec_c[i] && (cnt_q[i] != CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (dec_c[i] && !inc_c[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
      if (flush_i || (i == 0)) begin
        cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

`ifdef REGFILE_WB_BYPASS_EN
  assign rs_resolved_o = (cnt_q[rs_addr] == '0) ||
                         ((cnt_q[rs_addr] == CNT_W'(1)) && wr_regwr && (wr_regdst_addr == rs_addr));
  assign rt_resolved_o = (cnt_q[rt_addr] == '0) ||
                         ((cnt_q[rt_addr] == CNT_W'(1)) && wr_regwr && (wr_regdst_addr == rt_addr));
`else
  assign rs_resolved_o = (cnt_q[rs_addr] == '0);
  assign rt_resolved_o = (cnt_q[rt_addr] == '0);
`endif

endmodule : regfile_scoreboard

// File: rtl/regfile_wb.sv
// 32x32 register file with writeback port and pending-write scoreboard stall.
// Optional feature: REGFILE_WB_BYPASS_EN forwards same-cycle writeback data to the read ports.
import cpu_pkg::*;

module regfile_wb (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_regwr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [REG_ADDR_W-1:0] wr_regdst_addr,
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [REG_ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0]     rs_data,
  output logic [DATA_W-1:0]     rt_data,
  input  logic                  issue_valid,
  input  logic                  issue_regwr,
  input  logic [REG_ADDR_W-1:0] issue_dst_addr,
  input  logic                  flush_i,
  output logic                  stall_o
);

  word_t mem_q [NUM_REGS];
  logic  rs_resolved;
  logic  rt_resolved;

  // Register 0 is never written, so it always reads back as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_regwr && (wr_regdst_addr != REG_ZERO)) begin
      mem_q[wr_regdst_addr] <= wr_data;
    end
  end

  always_comb begin
    rs_data = (rs_addr == REG_ZERO) ? '0 : mem_q[rs_addr];
    rt_data = (rt_addr == REG_ZERO) ? '0 : mem_q[rt_addr];
`ifdef REGFILE_WB_BYPASS_EN
    if (wr_regwr && (wr_regdst_addr == rs_addr) && (rs_addr != REG_ZERO)) begin
      rs_data = wr_data;
    end
    if (wr_regwr && (wr_regdst_addr == rt_addr) && (rt_addr != REG_ZERO)) begin
      rt_data = wr_data;
    end
`endif
  end

  regfile_scoreboard u_scoreboard (
    .clk            (clk),
    .reset          (reset),
    .wr_regwr       (wr_regwr),
    .wr_regdst_addr (wr_regdst_addr),
    .issue_valid    (issue_valid),
    .issue_regwr    (issue_regwr),
    .issue_dst_addr (issue_dst_addr),
    .flush_i        (flush_i),
    .rs_addr        (rs_addr),
    .rt_addr        (rt_addr),
    .rs_resolved_o  (rs_resolved),
    .rt_resolved_o  (rt_resolved)
  );

  assign stall_o = ((rs_addr != REG_ZERO) && !rs_resolved) ||
                   ((rt_addr != REG_ZERO) && !rt_resolved);

endmodule : regfile_wb

// File: doc/regfile_wb.md
REGFILE_WB -- requirements
Module: regfile_wb

Interface
REQ-001 Clock clk, reset reset, synchronous, active-high.
REQ-002 clk  input  1  rising-edge clock for array, scoreboard.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 wr_regwr  input  1  writeback write enable from MEM/WB register.
REQ-005 wr_data  input  32  writeback data.
REQ-006 wr_regdst_addr  input  5  writeback destination register.
REQ-007 rs_addr, rt_addr  input  5 each  decode-stage read addresses.
REQ-008 rs_data, rt_data  output  32 each  read data, combinational.
REQ-009 issue_valid  input  1  decode instruction leaves ID this cycle.
REQ-010 issue_regwr  input  1  issuing instruction writes a register.
REQ-011 issue_dst_addr  input  5  issuing instruction destination.
REQ-012 flush_i  input  1  stages beyond ID washed; pending writes cancelled.
REQ-013 stall_o  output  1  decode must hold: operand has an unresolved pending write.

Function
REQ-014 Array: 32 x 32-bit; register 0 reads 0 always; writes to address 0 discarded.
REQ-015 Write: on rising clk with wr_regwr=1 and wr_regdst_addr!=0, array[wr_regdst_addr] <= wr_data; one write per cycle.
REQ-016 Read: rs_data/rt_data = array[addr] combinationally, zero latency.
REQ-017 Scoreboard: per-register 2-bit pending counter cnt[1..31]; cnt[0] constant 0.
REQ-018 inc condition: issue_valid & issue_regwr & issue_dst_addr!=0; dec condition: wr_regwr & wr_regdst_addr!=0 & cnt[wr_regdst_addr]!=0.
REQ-019 Same register inc and dec in one cycle: counter unchanged.
REQ-020 inc only: counter +1, saturating at 3 (no wrap to 0).
REQ-021 dec only: counter -1; writeback to counter 0 updates array, counter stays 0 (no underflow).
REQ-022 flush_i=1: all counters cleared to 0 next edge, overriding inc/dec; array write in same cycle still performed.
REQ-023 stall_o = 1 iff (rs_addr!=0 and rs not resolved) or (rt_addr!=0 and rt not resolved); resolved = cnt==0, or (WB_BYPASS_EN and cnt==1 and wr_regwr and wr_regdst_addr==addr).
REQ-024 stall_o combinational; issue_valid during stall_o=1 is a caller error, behaviour unspecified.

Reset
REQ-025 reset=1 at rising clk: all counters 0, all array entries 0; overrides write, issue, flush.
REQ-026 After reset: rs_data=rt_data=0, stall_o=0 for any addresses.
REQ-027 reset mid-operation discards all pending state; no writeback in the reset cycle takes effect.

Configuration
REQ-028 Macro REGFILE_WB_BYPASS_EN defined: same-cycle writeback forwarded — if wr_regwr and wr_regdst_addr==read addr!=0, read data = wr_data; REQ-023 bypass term active.
REQ-029 Macro undefined: reads return array contents only; same-cycle writeback not visible until next cycle; stall_o held until counter reaches 0.

Structure
REQ-030 Shared package (cpu_pkg): REG_ADDR_W=5, DATA_W=32, NUM_REGS=32, REG_ZERO=0, typedefs reg_addr_t, word_t.
REQ-031 One sub-module: regfile_scoreboard (counters, inc/dec/flush, per-port resolved flags); array, read mux in top level.

Verification
REQ-032 reset; write r5=0xDEADBEEF; next cycle rs_addr=5 -> rs_data=0xDEADBEEF, stall_o=0.
REQ-033 write r0=0x12345678; rs_addr=0 -> rs_data=0, stall_o=0 even with pending issue to r0.
REQ-034 issue r7; rt_addr=7 -> stall_o=1; wb r7=0x55 same cycle -> stall_o=0 and rt_data=0x55 with BYPASS_EN, stall_o=1 without; next cycle stall_o=0, rt_data=0x55.
REQ-035 four issues to r3, no writeback -> counter saturates 3; three writebacks -> stall_o=0 on rs_addr=3.
REQ-036 issue r9 and wb r9 same cycle with cnt=1 -> cnt stays 1, stall_o=1 on r9; flush_i -> next cycle stall_o=0.
REQ-037 reset asserted with wr_regwr=1 to r4=0xAA -> r4 reads 0, all stall_o=0.
